minilogix_cfg_loader: RTL and testbench

- Configuration sequencer for the minilogix programmable logic core.
- Accepts configuration bytes over a valid/ready stream and bit-bangs them onto the core's serial load interface (load_en, load_clk, load_dat), generating its own slow load clock from clk.
- Sits between the top-level IO pins (or an on-chip config ROM) and the logic core, so the core can be programmed from a byte-wide source without external bit-banging.

---
 rtl/minilogix_cfg_loader.sv | 163 ++++++++++++++++
 tb/tb_minilogix_cfg_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/minilogix_cfg_loader.sv
// Configuration sequencer: accepts words over valid/ready and bit-bangs them
// MSB first onto the logic core's serial load interface with a divided load clock.
module minilogix_cfg_loader #(
   parameter int unsigned CFG_BITS = 64,
   parameter int unsigned WORD_W   = 8,
   parameter int unsigned HALF     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [WORD_W-1:0] i_word,
   input  logic              i_word_valid,
   output logic              o_word_ready,
   output logic              o_load_en,
   output logic              o_load_clk,
   output logic              o_load_dat,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_aborted,
   output logic [2:0]        o_state
);

   localparam int unsigned HW = $clog2(HALF + 1);
   localparam int unsigned TW = $clog2(CFG_BITS + 1);
   localparam int unsigned BW = $clog2(WORD_W + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SETUP    = 3'd1,
      S_FETCH    = 3'd2,
      S_SHIFT_LO = 3'd3,
      S_SHIFT_HI = 3'd4,
      S_HOLD     = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [HW-1:0]     half_q, half_d;
   logic [TW-1:0]     btot_q, btot_d;
   logic [BW-1:0]     biw_q, biw_d;
   logic [WORD_W-1:0] sr_q, sr_d;
   logic              rdy_q, rdy_d;
   logic              en_q, en_d;
   logic              lclk_q, lclk_d;
   logic              dat_q, dat_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;
   logic              half_last;

   // Next-state, datapath and next-output logic
   always_comb begin
      state_d   = state_q;
      half_d    = half_q;
      btot_d    = btot_q;
      biw_d     = biw_q;
      sr_d      = sr_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      half_last = (half_q == HW'(HALF - 1));

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_SETUP;
               btot_d  = TW'(CFG_BITS);
            end
         end
         S_SETUP: begin
            if (half_last) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (i_word_valid && rdy_q) begin
               sr_d    = i_word;
               biw_d   = BW'(WORD_W);
               state_d = S_SHIFT_LO;
            end
         end
         S_SHIFT_LO: begin
            if (half_last) state_d = S_SHIFT_HI;
         end
         S_SHIFT_HI: begin
            if (half_last) begin
               sr_d   = sr_q << 1;
               biw_d  = biw_q - BW'(1);
               btot_d = btot_q - TW'(1);
               if (btot_q == TW'(1))     state_d = S_HOLD;
               else if (biw_q == BW'(1)) state_d = S_FETCH;
               else                      state_d = S_SHIFT_LO;
            end
         end
         S_HOLD: begin
            if (half_last) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (i_abort && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         done_d    = 1'b0;
         aborted_d = 1'b1;
      end

      // Half-period timer only runs in the timed states and restarts on every transition
      if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_FETCH))
         half_d = '0;
      else
         half_d = half_q + HW'(1);

      busy_d = (state_d != S_IDLE);
      en_d   = (state_d != S_IDLE);
      lclk_d = (state_d == S_SHIFT_HI);
      rdy_d  = (state_d == S_FETCH);
      case (state_d)
         S_SHIFT_LO:                  dat_d = sr_d[WORD_W-1];
         S_FETCH, S_SHIFT_HI, S_HOLD: dat_d = dat_q;
         default:                     dat_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         half_q    <= '0;
         btot_q    <= '0;
         biw_q     <= '0;
         sr_q      <= '0;
         rdy_q     <= 1'b0;
         en_q      <= 1'b0;
         lclk_q    <= 1'b0;
         dat_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         half_q    <= half_d;
         btot_q    <= btot_d;
         biw_q     <= biw_d;
         sr_q      <= sr_d;
         rdy_q     <= rdy_d;
         en_q      <= en_d;
         lclk_q    <= lclk_d;
         dat_q     <= dat_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign o_word_ready = rdy_q;
   assign o_load_en    = en_q;
   assign o_load_clk   = lclk_q;
   assign o_load_dat   = dat_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_aborted    = aborted_q;
   assign o_state      = state_q;

endmodule

// File: tb/tb_minilogix_cfg_loader.sv
// Directed bench: a 16-bit/HALF=2 loader and an 8-bit/HALF=1 loader side by side.
module tb_minilogix_cfg_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1, start_a = 1'b0, abort_a = 1'b0, valid_a = 1'b0;
   logic [7:0] word_a = 8'h00;
   logic       rdy_a, en_a, lclk_a, dat_a, busy_a, done_a, abt_a;
   logic [2:0] st_a;

   logic       rst_b = 1'b1, start_b = 1'b0, abort_b = 1'b0, valid_b = 1'b0;
   logic [7:0] word_b = 8'h00;
   logic       rdy_b, en_b, lclk_b, dat_b, busy_b, done_b, abt_b;
   logic [2:0] st_b;

   minilogix_cfg_loader #(.CFG_BITS(16), .WORD_W(8), .HALF(2)) u_dut_a (
      .clk(clk), .rst(rst_a), .i_start(start_a), .i_abort(abort_a),
      .i_word(word_a), .i_word_valid(valid_a), .o_word_ready(rdy_a),
      .o_load_en(en_a), .o_load_clk(lclk_a), .o_load_dat(dat_a),
      .o_busy(busy_a), .o_done(done_a), .o_aborted(abt_a), .o_state(st_a)
   );

   minilogix_cfg_loader #(.CFG_BITS(8), .WORD_W(8), .HALF(1)) u_dut_b (
      .clk(clk), .rst(rst_b), .i_start(start_b), .i_abort(abort_b),
      .i_word(word_b), .i_word_valid(valid_b), .o_word_ready(rdy_b),
      .o_load_en(en_b), .o_load_clk(lclk_b), .o_load_dat(dat_b),
      .o_busy(busy_b), .o_done(done_b), .o_aborted(abt_b), .o_state(st_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Cumulative activity counters sampled away from the active edge
   int          edges_a = 0, encyc_a = 0, ndone_a = 0, nabt_a = 0;
   int          edges_b = 0, encyc_b = 0, ndone_b = 0, hicyc_b = 0;
   logic [31:0] data_a = '0, data_b = '0;
   logic        pclk_a = 1'b0, pclk_b = 1'b0;

   always @(negedge clk) begin
      if (lclk_a && !pclk_a) begin
         edges_a <= edges_a + 1;
         data_a  <= {data_a[30:0], dat_a};
      end
      pclk_a  <= lclk_a;
      encyc_a <= encyc_a + (en_a ? 1 : 0);
      ndone_a <= ndone_a + (done_a ? 1 : 0);
      nabt_a  <= nabt_a + (abt_a ? 1 : 0);
      if (lclk_b && !pclk_b) begin
         edges_b <= edges_b + 1;
         data_b  <= {data_b[30:0], dat_b};
      end
      pclk_b  <= lclk_b;
      encyc_b <= encyc_b + (en_b ? 1 : 0);
      ndone_b <= ndone_b + (done_b ? 1 : 0);
      hicyc_b <= hicyc_b + (lclk_b ? 1 : 0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One load on the 16-bit loader; optional FETCH stall, abort at a given edge, start spamming
   task automatic load_a(input logic [7:0] w0, input logic [7:0] w1, input int stall,
                         input int abort_bit, input bit spam);
      int  e0, c0, d0, a0, idx, stall_left, ledges;
      bit  hs, fin, do_abort, plclk;
      e0 = edges_a; c0 = encyc_a; d0 = ndone_a; a0 = nabt_a;
      idx = 0; stall_left = stall; ledges = 0; fin = 0; plclk = 0; do_abort = 0;
      word_a = w0; valid_a = 1'b1; start_a = 1'b1;
      cyc();
      start_a = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (!busy_a) begin
            fin = 1;
            break;
         end
         if (lclk_a && !plclk) ledges++;
         plclk = lclk_a;
         hs = rdy_a && valid_a;
         if (idx == 1 && rdy_a && !valid_a) begin
            chk("stall_lclk", lclk_a, 0);
            chk("stall_en", en_a, 1);
            chk("stall_rdy", rdy_a, 1);
            stall_left--;
         end
         do_abort = (abort_bit > 0) && (ledges == abort_bit) && lclk_a;
         @(posedge clk);
         #1;
         if (hs) begin
            idx++;
            word_a = w1;
            if (idx == 1 && stall > 0) valid_a = 1'b0;
         end
         if (idx == 1 && stall > 0 && stall_left == 0) valid_a = 1'b1;
         abort_a = do_abort;
         start_a = spam && (n % 2 == 0) && (ledges < 12);
      end
      chk("a_finished", 32'(fin), 1);
      abort_a = 1'b0; start_a = 1'b0;
      if (abort_bit > 0) begin
         chk("abt_state", 32'(st_a), 0);
         chk("abt_en", en_a, 0);
         chk("abt_lclk", lclk_a, 0);
         chk("abt_dat", dat_a, 0);
         chk("abt_pulse", abt_a, 1);
         chk("abt_nodone", done_a, 0);
      end else begin
         chk("done_pulse", done_a, 1);
         chk("done_state", 32'(st_a), 0);
      end
      valid_a = 1'b0;
      repeat (3) cyc();
      chk("busy_after", busy_a, 0);
      if (abort_bit > 0) begin
         chk("abt_edges", 32'(edges_a - e0), 32'(abort_bit));
         chk("abt_count", 32'(nabt_a - a0), 1);
         chk("abt_donecnt", 32'(ndone_a - d0), 0);
      end else begin
         chk("edges", 32'(edges_a - e0), 16);
         chk("data", 32'(data_a[15:0]), 32'({w0, w1}));
         chk("en_cycles", 32'(encyc_a - c0), 32'(70 + stall));
         chk("done_count", 32'(ndone_a - d0), 1);
         chk("no_abort", 32'(nabt_a - a0), 0);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int e0, c0, d0, h0;
      bit seen;
      repeat (3) cyc();
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      chk("rst_state", 32'(st_a), 0);
      chk("rst_en", en_a, 0);
      chk("rst_lclk", lclk_a, 0);
      chk("rst_dat", dat_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_rdy", rdy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_abt", abt_a, 0);
      chk("rst_b_state", 32'(st_b), 0);
      chk("rst_b_en", en_b, 0);

      // abort while idle does nothing
      cyc();
      abort_a = 1'b1;
      cyc();
      abort_a = 1'b0;
      @(negedge clk);
      chk("idle_abt_pulse", abt_a, 0);
      chk("idle_abt_state", 32'(st_a), 0);

      cyc();
      load_a(8'hA5, 8'h3C, 0, 0, 0);
      load_a(8'hA5, 8'h3C, 5, 0, 0);
      load_a(8'hA5, 8'h3C, 0, 5, 0);
      load_a(8'hA5, 8'h3C, 0, 0, 0);
      load_a(8'h81, 8'h7E, 0, 0, 1);

      // reset while in SHIFT_LO
      word_a = 8'hC3; valid_a = 1'b1; start_a = 1'b1;
      cyc();
      start_a = 1'b0;
      seen = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (st_a == 3'd3) begin
            seen = 1;
            break;
         end
      end
      chk("reach_shift_lo", 32'(seen), 1);
      cyc();
      rst_a = 1'b1;
      cyc();
      rst_a = 1'b0; valid_a = 1'b0;
      @(negedge clk);
      chk("mrst_state", 32'(st_a), 0);
      chk("mrst_en", en_a, 0);
      chk("mrst_lclk", lclk_a, 0);
      chk("mrst_dat", dat_a, 0);
      chk("mrst_busy", busy_a, 0);
      chk("mrst_rdy", rdy_a, 0);
      cyc();
      load_a(8'h5A, 8'hF0, 0, 0, 0);

      // HALF=1, 8-bit load of 0xFF
      e0 = edges_b; c0 = encyc_b; d0 = ndone_b; h0 = hicyc_b;
      word_b = 8'hFF; valid_b = 1'b1; start_b = 1'b1;
      cyc();
      start_b = 1'b0;
      seen = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (!busy_b) begin
            seen = 1;
            break;
         end
      end
      chk("b_finished", 32'(seen), 1);
      chk("b_done_pulse", done_b, 1);
      valid_b = 1'b0;
      repeat (3) cyc();
      chk("b_edges", 32'(edges_b - e0), 8);
      chk("b_data", 32'(data_b[7:0]), 32'hFF);
      chk("b_hi_cycles", 32'(hicyc_b - h0), 8);
      chk("b_en_cycles", 32'(encyc_b - c0), 32'(1 + 1 + 16 + 1));
      chk("b_done_count", 32'(ndone_b - d0), 1);
      chk("b_rdy_idle", rdy_b, 0);
      chk("b_abt_idle", abt_b, 0);
      chk("b_state_idle", 32'(st_b), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
